// File: rtl/memory_page_pkg.sv
// Shared definitions for the memory page arbiter.
// Holds default widths/requester count and the FSM state type used by the top.
package memory_page_pkg;

  localparam int DEFAULT_NUM_REQ    = 4;
  localparam int DEFAULT_ADDR_WIDTH = 13;
  localparam int DEFAULT_ELEM_WIDTH = 8;

  // One transaction in flight: arbitrate, touch the page, report back.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner search, purely combinational.
// Ports:
//   req        - request vector, one bit per requester
//   last_grant - index of the most recently granted requester
//   grant      - one-hot winner (all zero when nothing requests)
//   idx        - encoded winner index (0 when nothing requests)
//   any_req    - high when at least one request bit is set
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any_req
);

  logic found;
  int   cand;

  // Walk from last_grant+1 around the ring; the first set bit wins, so the
  // requester just served ends up with the lowest priority.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = int'(last_grant) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        idx   = cand[IDX_W-1:0];
      end
    end
    any_req = found;
    grant   = found ? (NUM_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/memory_page_arbiter.sv
// Memory page arbiter: round-robin arbitration of NUM_REQ requesters onto a
// single memory page with registered read data. One transaction at a time,
// fixed latency: handshake edge T, memory cycle T+1, response cycle T+2.
// Ports:
//   clk_i, arst_ni                  - clock, asynchronous active-low reset
//   req_valid_i/write_i/addr_i/wdata_i - per-requester request (flattened)
//   req_ready_o                     - one-hot grant/accept, IDLE only
//   rsp_valid_o, rsp_rdata_o        - one-hot completion pulse and read data
//   mem_we_o, mem_addr_o, mem_wdata_o, mem_rdata_i - memory page port
//   busy_o                          - high whenever the FSM is not IDLE
module memory_page_arbiter
  import memory_page_pkg::*;
#(
  parameter int NUM_REQ    = DEFAULT_NUM_REQ,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int ELEM_WIDTH = DEFAULT_ELEM_WIDTH
) (
  input  logic                          clk_i,
  input  logic                          arst_ni,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ-1:0]            req_write_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*ELEM_WIDTH-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  output logic [ELEM_WIDTH-1:0]         rsp_rdata_o,
  output logic                          mem_we_o,
  output logic [ADDR_WIDTH-1:0]         mem_addr_o,
  output logic [ELEM_WIDTH-1:0]         mem_wdata_o,
  input  logic [ELEM_WIDTH-1:0]         mem_rdata_i,
  output logic                          busy_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t                 state_reg, state_next;
  logic [IDX_W-1:0]       last_grant_reg;
  logic [IDX_W-1:0]       idx_reg;
  logic                   write_reg;
  logic [ADDR_WIDTH-1:0]  addr_reg;
  logic [ELEM_WIDTH-1:0]  wdata_reg;

  logic [NUM_REQ-1:0]     win_grant;
  logic [IDX_W-1:0]       win_idx;
  logic                   win_any;
  logic                   handshake;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req        (req_valid_i),
    .last_grant (last_grant_reg),
    .grant      (win_grant),
    .idx        (win_idx),
    .any_req    (win_any)
  );

  // The winner is always a valid requester, so IDLE plus any request is a
  // handshake at the next edge.
  assign handshake = (state_reg == ST_IDLE) && win_any;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (win_any) state_next = ST_ACCESS;
      ST_ACCESS: state_next = ST_RESP;
      ST_RESP:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_reg      <= ST_IDLE;
      last_grant_reg <= IDX_W'(NUM_REQ - 1);  // requester 0 first after reset
      idx_reg        <= '0;
      write_reg      <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
    end else begin
      state_reg <= state_next;
      if (handshake) begin
        last_grant_reg <= win_idx;
        idx_reg        <= win_idx;
        write_reg      <= req_write_i[win_idx];
        addr_reg       <= req_addr_i[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
        wdata_reg      <= req_wdata_i[win_idx*ELEM_WIDTH +: ELEM_WIDTH];
      end
    end
  end

  // Ready is combinational; it is also masked by reset so that every output
  // reads 0 while arst_ni is held low, even with requests pending.
  assign req_ready_o = (arst_ni && (state_reg == ST_IDLE)) ? win_grant : '0;

  assign mem_addr_o  = addr_reg;
  assign mem_we_o    = (state_reg == ST_ACCESS) && write_reg;
  assign mem_wdata_o = ((state_reg == ST_ACCESS) && write_reg) ? wdata_reg : '0;

  assign rsp_valid_o = (state_reg == ST_RESP) ? (NUM_REQ'(1) << idx_reg) : '0;
  assign rsp_rdata_o = ((state_reg == ST_RESP) && !write_reg) ? mem_rdata_i : '0;

  assign busy_o = (state_reg != ST_IDLE);

endmodule
